// File: rtl/spike_input_arbiter_pkg.sv
// Shared SNN definitions for the spike input arbiter: the timestep FSM
// encoding and the default interface widths.
package spike_input_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_WAIT_ARRAY = 2'd2,
    ST_DONE       = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_SRC         = 4;
  localparam int DEF_NEURON_ID_WIDTH = 6;
  localparam int DEF_WEIGHT_WIDTH    = 8;

endpackage

// File: rtl/spike_input_arbiter_rr_arbiter.sv
// Round-robin selector: the search starts one past the last granted source
// and wraps, so every requester is served within N grants.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spike_input_arbiter.sv
// Arbitrates per-source spikes into a one-entry output register feeding the
// neuron array, and sequences timestep close-out.
//
// state      | meaning
// RUN        | normal operation, grants allowed
// DRAIN      | step requested; wait for the output register to empty
// WAIT_ARRAY | register empty; wait for the neuron array to go idle
// DONE       | one-cycle step_done pulse, then back to RUN
module spike_input_arbiter
  import spike_input_arbiter_pkg::*;
#(
  parameter int NUM_SRC         = DEF_NUM_SRC,
  parameter int NEURON_ID_WIDTH = DEF_NEURON_ID_WIDTH,
  parameter int WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
  parameter int IDX_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_SRC-1:0]                 s_valid,
  input  logic [NUM_SRC*NEURON_ID_WIDTH-1:0] s_dest_id,
  input  logic [NUM_SRC*WEIGHT_WIDTH-1:0]    s_weight,
  input  logic [NUM_SRC-1:0]                 s_exc_inh,
  output logic [NUM_SRC-1:0]                 s_ready,
  output logic                               m_axis_spike_valid,
  output logic [NEURON_ID_WIDTH-1:0]         m_axis_spike_dest_id,
  output logic [WEIGHT_WIDTH-1:0]            m_axis_spike_weight,
  output logic                               m_axis_spike_exc_inh,
  input  logic                               m_axis_spike_ready,
  input  logic                               array_busy,
  input  logic                               step_req,
  output logic                               step_done,
  output logic [IDX_W-1:0]                   last_grant,
  output logic [31:0]                        accept_count
);

  arb_state_t state, state_nxt;

  logic [NUM_SRC-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_found;
  logic               can_load;
  logic               grant_ok;
  logic               accept;
  logic               xfer;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
    .req   (s_valid),
    .last  (last_grant),
    .grant (rr_grant),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign xfer     = m_axis_spike_valid && m_axis_spike_ready;
  assign can_load = !m_axis_spike_valid || m_axis_spike_ready;
  // The step_req cycle itself issues no grant so DRAIN starts from a fixed set.
  assign grant_ok = (state == ST_RUN) && enable && can_load && !step_req;
  assign accept   = grant_ok && rr_found;
  assign s_ready  = grant_ok ? rr_grant : '0;

  always_comb begin
    state_nxt = state;
    step_done = 1'b0;
    unique case (state)
      ST_RUN:        if (step_req) state_nxt = ST_DRAIN;
      ST_DRAIN:      if (!m_axis_spike_valid || xfer) state_nxt = ST_WAIT_ARRAY;
      ST_WAIT_ARRAY: if (!array_busy) state_nxt = ST_DONE;
      ST_DONE: begin
        step_done = 1'b1;
        state_nxt = ST_RUN;
      end
      default:       state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_RUN;
      m_axis_spike_valid   <= 1'b0;
      m_axis_spike_dest_id <= '0;
      m_axis_spike_weight  <= '0;
      m_axis_spike_exc_inh <= 1'b0;
      last_grant           <= IDX_W'(NUM_SRC - 1);
      accept_count         <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_axis_spike_valid   <= 1'b1;
        m_axis_spike_dest_id <= s_dest_id[rr_idx*NEURON_ID_WIDTH +: NEURON_ID_WIDTH];
        m_axis_spike_weight  <= s_weight[rr_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        m_axis_spike_exc_inh <= s_exc_inh[rr_idx];
        last_grant           <= rr_idx;
        if (accept_count != 32'hFFFF_FFFF) accept_count <= accept_count + 32'd1;
      end else if (xfer) begin
        m_axis_spike_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_input_arbiter.sv
// Directed bench for spike_input_arbiter with hand-computed expectations.
module tb_spike_input_arbiter;

  localparam int NS = 4;
  localparam int IW = 6;
  localparam int WW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [NS-1:0]   s_valid;
  logic [NS*IW-1:0] s_dest_id;
  logic [NS*WW-1:0] s_weight;
  logic [NS-1:0]   s_exc_inh;
  logic [NS-1:0]   s_ready;
  logic            m_valid;
  logic [IW-1:0]   m_dest;
  logic [WW-1:0]   m_weight;
  logic            m_exc;
  logic            m_ready;
  logic            array_busy;
  logic            step_req;
  logic            step_done;
  logic [1:0]      last_grant;
  logic [31:0]     accept_count;

  int n_total = 0;
  int n_bad   = 0;

  spike_input_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .s_valid              (s_valid),
    .s_dest_id            (s_dest_id),
    .s_weight             (s_weight),
    .s_exc_inh            (s_exc_inh),
    .s_ready              (s_ready),
    .m_axis_spike_valid   (m_valid),
    .m_axis_spike_dest_id (m_dest),
    .m_axis_spike_weight  (m_weight),
    .m_axis_spike_exc_inh (m_exc),
    .m_axis_spike_ready   (m_ready),
    .array_busy           (array_busy),
    .step_req             (step_req),
    .step_done            (step_done),
    .last_grant           (last_grant),
    .accept_count         (accept_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; s_valid = '0; s_exc_inh = '0;
    m_ready = 1'b1; array_busy = 1'b0; step_req = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_dest_id[i*IW +: IW] = IW'(10 + i);
      s_weight[i*WW +: WW]  = WW'(16 * i + 1);
      s_exc_inh[i]          = i[0];
    end

    // reset state
    cyc(); cyc();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_dest", 32'(m_dest), 0);
    chk("rst_weight", 32'(m_weight), 0);
    chk("rst_exc", 32'(m_exc), 0);
    chk("rst_sready", 32'(s_ready), 0);
    chk("rst_done", 32'(step_done), 0);
    chk("rst_last", 32'(last_grant), 3);
    chk("rst_count", accept_count, 0);

    // single source 2
    rst = 1'b0;
    s_dest_id[2*IW +: IW] = 6'd5;
    s_weight[2*WW +: WW]  = 8'h20;
    s_exc_inh[2]          = 1'b1;
    s_valid = 4'b0100;
    #1 chk("one_sready", 32'(s_ready), 4'b0100);
    cyc();
    s_valid = '0;
    chk("one_valid", 32'(m_valid), 1);
    chk("one_dest", 32'(m_dest), 5);
    chk("one_weight", 32'(m_weight), 8'h20);
    chk("one_exc", 32'(m_exc), 1);
    chk("one_count", accept_count, 1);
    chk("one_last", 32'(last_grant), 2);
    cyc();
    chk("one_drained", 32'(m_valid), 0);

    // full rotation from reset, 1 spike/cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    s_dest_id[2*IW +: IW] = 6'd12;
    s_exc_inh[2] = 1'b0;
    s_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rot_sready", 32'(s_ready), 32'(1) << (k % 4));
      cyc();
      if (k == 7) s_valid = '0;
      chk("rot_valid", 32'(m_valid), 1);
      chk("rot_dest", 32'(m_dest), 32'(10 + k % 4));
    end
    chk("rot_count", accept_count, 8);
    chk("rot_last", 32'(last_grant), 3);
    cyc();
    chk("rot_drained", 32'(m_valid), 0);

    // backpressure hold
    s_valid = 4'b0010; m_ready = 1'b0;
    #1 chk("bp_first", 32'(s_ready), 4'b0010);
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_sready", 32'(s_ready), 0);
      cyc();
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_dest", 32'(m_dest), 11);
      chk("bp_weight", 32'(m_weight), 8'h11);
    end
    s_valid = '0; m_ready = 1'b1;
    cyc();
    chk("bp_xfer", 32'(m_valid), 0);
    chk("bp_count", accept_count, 9);

    // timestep close-out with a held spike and a busy array
    s_valid = 4'b0001; m_ready = 1'b0;
    cyc();
    chk("st_held", 32'(m_dest), 10);
    s_valid = 4'b1111; step_req = 1'b1; array_busy = 1'b1;
    #1 chk("st_req_nogrant", 32'(s_ready), 0);
    cyc();
    step_req = 1'b0;
    #1 chk("st_drain_nogrant", 32'(s_ready), 0);
    cyc();
    chk("st_drain_held", 32'(m_valid), 1);
    chk("st_drain_done", 32'(step_done), 0);
    m_ready = 1'b1;
    cyc();
    chk("st_drained", 32'(m_valid), 0);
    for (int k = 0; k < 2; k++) begin
      step_req = (k == 0);
      #1 chk("st_wait_nogrant", 32'(s_ready), 0);
      chk("st_wait_done", 32'(step_done), 0);
      cyc();
    end
    step_req = 1'b0; array_busy = 1'b0;
    #1 chk("st_wait_last", 32'(step_done), 0);
    cyc();
    chk("st_done_pulse", 32'(step_done), 1);
    chk("st_done_nogrant", 32'(s_ready), 0);
    cyc();
    chk("st_done_clear", 32'(step_done), 0);
    chk("st_run_grant", 32'(s_ready), 4'b0010);
    s_valid = '0;
    cyc();
    chk("st_count", accept_count, 10);
    chk("st_no_redrain", 32'(step_done), 0);

    // enable gating
    s_valid = 4'b0100; m_ready = 1'b0;
    #1 chk("en_load", 32'(s_ready), 4'b0100);
    cyc();
    enable = 1'b0; s_valid = 4'b1111; m_ready = 1'b1;
    #1 chk("en_off_sready", 32'(s_ready), 0);
    cyc();
    chk("en_off_drain", 32'(m_valid), 0);
    #1 chk("en_off_sready2", 32'(s_ready), 0);
    cyc();
    chk("en_off_idle", 32'(m_valid), 0);
    enable = 1'b1;
    #1 chk("en_resume", 32'(s_ready), 4'b1000);
    cyc();
    s_valid = '0;
    chk("en_dest", 32'(m_dest), 13);
    chk("en_count", accept_count, 12);
    cyc();

    // reset mid-step with a held spike
    s_valid = 4'b0001; m_ready = 1'b0; array_busy = 1'b1;
    cyc();
    s_valid = '0; step_req = 1'b1;
    cyc();
    step_req = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_valid", 32'(m_valid), 0);
    chk("mr_done", 32'(step_done), 0);
    chk("mr_count", accept_count, 0);
    array_busy = 1'b0; s_valid = 4'b0100;
    #1 chk("mr_run", 32'(s_ready), 4'b0100);
    cyc();
    s_valid = '0;
    chk("mr_done2", 32'(step_done), 0);
    cyc();
    chk("mr_done3", 32'(step_done), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
